// File: rtl/uart_tx_core.sv
// -----------------------------------------------------------------------------
// uart_tx_core
//
// Parallel-to-serial UART transmitter that sends one frame bit per CLK cycle:
// a start bit, the data bits LSB first, an optional parity bit, and a stop bit.
// CLK is the bit clock, so there is no internal baud divider.
//
// Ports:
//   CLK            bit clock; all state changes happen on its rising edge
//   RST            asynchronous, active-low reset
//   TX_P_DATA      parallel data word (Data_width bits)
//   TX_Data_valid  single-cycle request; data and parity config are valid with it
//   PAR_EN         1 = append a parity bit after the data bits
//   PAR_TYP        0 = even parity, 1 = odd parity
//   TX_OUT         serial line; idles high
//   busy           high while a frame is on the line
//
// TX_OUT and busy are driven straight from flops. Each flop is loaded with
// the value that belongs to the next state, so the line changes in the same
// cycle as the state and no decode glitch can reach the pin.
// -----------------------------------------------------------------------------
module uart_tx_core #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] TX_P_DATA,
    input  logic                  TX_Data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int CNT_W = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Data_width - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit on the line: XOR of the data for even parity, inverted for odd.
    function automatic logic parity_bit(input logic [Data_width-1:0] data,
                                        input logic                  odd);
        return (^data) ^ odd;
    endfunction

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [Data_width-1:0]   data_r;
    logic [Data_width-1:0]   data_nxt_s;
    logic                    par_en_r;
    logic                    par_en_nxt_s;
    logic                    par_typ_r;
    logic                    par_typ_nxt_s;
    logic                    tx_out_r;
    logic                    tx_out_nxt_s;
    logic                    busy_r;
    logic                    busy_nxt_s;
    logic                    accept_s;

    // A request is taken only while idle; it is ignored in every other state, including STOP.
    assign accept_s = (state_r == ST_IDLE) && TX_Data_valid;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_nxt_s = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_r != CNT_LAST) begin
                    state_nxt_s = ST_DATA;
                end else if (par_en_r) begin
                    state_nxt_s = ST_PARITY;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_PARITY: begin
                state_nxt_s = ST_STOP;
            end
            ST_STOP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the bit counter and the latched frame data and config.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        data_nxt_s    = data_r;
        par_en_nxt_s  = par_en_r;
        par_typ_nxt_s = par_typ_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    data_nxt_s    = TX_P_DATA;
                    par_en_nxt_s  = PAR_EN;
                    par_typ_nxt_s = PAR_TYP;
                end else begin
                    data_nxt_s    = data_r;
                    par_en_nxt_s  = par_en_r;
                    par_typ_nxt_s = par_typ_r;
                end
                cnt_nxt_s = '0;
            end
            ST_START: begin
                cnt_nxt_s = '0;
            end
            ST_DATA: begin
                if (cnt_r != CNT_LAST) begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            ST_PARITY: begin
                cnt_nxt_s = '0;
            end
            ST_STOP: begin
                cnt_nxt_s = '0;
            end
            default: begin
                cnt_nxt_s = '0;
            end
        endcase
    end

    // Datapath registers: bit counter, latched data and parity config.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r     <= '0;
            data_r    <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            data_r    <= data_nxt_s;
            par_en_r  <= par_en_nxt_s;
            par_typ_r <= par_typ_nxt_s;
        end
    end

    // Output decode for the state being entered, so the output flops track the state register.
    always_comb begin
        tx_out_nxt_s = 1'b1;
        busy_nxt_s   = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                tx_out_nxt_s = 1'b1;
                busy_nxt_s   = 1'b0;
            end
            ST_START: begin
                tx_out_nxt_s = 1'b0;
                busy_nxt_s   = 1'b1;
            end
            ST_DATA: begin
                tx_out_nxt_s = data_nxt_s[cnt_nxt_s];
                busy_nxt_s   = 1'b1;
            end
            ST_PARITY: begin
                tx_out_nxt_s = parity_bit(data_nxt_s, par_typ_nxt_s);
                busy_nxt_s   = 1'b1;
            end
            ST_STOP: begin
                tx_out_nxt_s = 1'b1;
                busy_nxt_s   = 1'b1;
            end
            default: begin
                tx_out_nxt_s = 1'b1;
                busy_nxt_s   = 1'b0;
            end
        endcase
    end

    // Output registers; reset forces the line idle at once, even mid-frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            tx_out_r <= tx_out_nxt_s;
            busy_r   <= busy_nxt_s;
        end
    end

    assign TX_OUT = tx_out_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_uart_tx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_core
//
// Directed bench for uart_tx_core. It drives inputs on the falling edge and
// samples outputs on the falling edge. Each expected frame is a hand-written
// bit string, with the first bit on the line written leftmost.
// -----------------------------------------------------------------------------
module tb_uart_tx_core;

    logic       CLK_tb = 1'b0;
    logic       RST_tb;
    logic [7:0] tx_p_data_tb;
    logic       tx_data_valid_tb;
    logic       par_en_tb;
    logic       par_typ_tb;
    logic       tx_out_tb;
    logic       busy_tb;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_core #(.Data_width(8)) dut (
        .CLK           (CLK_tb),
        .RST           (RST_tb),
        .TX_P_DATA     (tx_p_data_tb),
        .TX_Data_valid (tx_data_valid_tb),
        .PAR_EN        (par_en_tb),
        .PAR_TYP       (par_typ_tb),
        .TX_OUT        (tx_out_tb),
        .busy          (busy_tb)
    );

    always #5 CLK_tb = ~CLK_tb;

    // Single comparison point: counts every vector and reports miscompares.
    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Send one frame and check every line bit plus busy.
    // exp holds the frame in line order in its low len bits.
    // glitch_at >= 0 raises a 0x55 request during that frame cycle, which must be ignored.
    task automatic send_frame(input logic [7:0]  d,
                              input logic        pe,
                              input logic        pt,
                              input logic [10:0] exp,
                              input int          len,
                              input int          glitch_at,
                              input string       tag);
        @(negedge CLK_tb);
        tx_p_data_tb     = d;
        par_en_tb        = pe;
        par_typ_tb       = pt;
        tx_data_valid_tb = 1'b1;
        @(negedge CLK_tb);
        // Scramble the inputs after the request; only the latched copy may matter.
        tx_data_valid_tb = 1'b0;
        tx_p_data_tb     = ~d;
        par_en_tb        = ~pe;
        par_typ_tb       = ~pt;
        for (int j = 0; j < len; j++) begin
            chk($sformatf("%s line c%0d", tag, j), tx_out_tb, exp[len-1-j]);
            chk($sformatf("%s busy c%0d", tag, j), busy_tb, 1'b1);
            if (j == glitch_at) begin
                tx_data_valid_tb = 1'b1;
                tx_p_data_tb     = 8'h55;
                par_en_tb        = 1'b1;
            end else begin
                tx_data_valid_tb = 1'b0;
            end
            @(negedge CLK_tb);
        end
        tx_data_valid_tb = 1'b0;
        chk({tag, " idle line"}, tx_out_tb, 1'b1);
        chk({tag, " idle busy"}, busy_tb, 1'b0);
        @(negedge CLK_tb);
        chk({tag, " idle2 line"}, tx_out_tb, 1'b1);
        chk({tag, " idle2 busy"}, busy_tb, 1'b0);
    endtask

    initial begin
        RST_tb           = 1'b0;
        tx_p_data_tb     = 8'h00;
        tx_data_valid_tb = 1'b0;
        par_en_tb        = 1'b0;
        par_typ_tb       = 1'b0;
        repeat (3) @(negedge CLK_tb);
        chk("reset line", tx_out_tb, 1'b1);
        chk("reset busy", busy_tb, 1'b0);
        RST_tb = 1'b1;
        @(negedge CLK_tb);
        chk("post-reset line", tx_out_tb, 1'b1);
        chk("post-reset busy", busy_tb, 1'b0);

        send_frame(8'h00, 1'b0, 1'b0, 11'b00000000001, 10, -1, "d00");
        send_frame(8'hFF, 1'b0, 1'b0, 11'b00111111111, 10, -1, "dFF");
        send_frame(8'h01, 1'b0, 1'b0, 11'b00100000001, 10, -1, "d01");
        send_frame(8'hAB, 1'b0, 1'b0, 11'b00110101011, 10, -1, "dAB");
        send_frame(8'h48, 1'b1, 1'b0, 11'b00001001001, 11, -1, "d48 even");
        send_frame(8'h48, 1'b1, 1'b1, 11'b00001001011, 11, -1, "d48 odd");
        // A request raised mid-data and one raised during the STOP cycle must both be ignored.
        send_frame(8'hAB, 1'b0, 1'b0, 11'b00110101011, 10, 4,  "dAB glitch");
        send_frame(8'h48, 1'b1, 1'b1, 11'b00001001011, 11, 10, "d48 stopglitch");

        // Assert reset while data bit 3 of a 0x00 frame is on the line.
        @(negedge CLK_tb);
        tx_p_data_tb     = 8'h00;
        par_en_tb        = 1'b0;
        par_typ_tb       = 1'b0;
        tx_data_valid_tb = 1'b1;
        @(negedge CLK_tb);
        tx_data_valid_tb = 1'b0;
        for (int j = 0; j < 5; j++) begin
            chk($sformatf("abort line c%0d", j), tx_out_tb, 1'b0);
            chk($sformatf("abort busy c%0d", j), busy_tb, 1'b1);
            if (j < 4) begin
                @(negedge CLK_tb);
            end
        end
        RST_tb = 1'b0;
        #1;
        chk("abort async line", tx_out_tb, 1'b1);
        chk("abort async busy", busy_tb, 1'b0);
        @(negedge CLK_tb);
        chk("abort held line", tx_out_tb, 1'b1);
        chk("abort held busy", busy_tb, 1'b0);
        RST_tb = 1'b1;
        @(negedge CLK_tb);
        send_frame(8'h01, 1'b0, 1'b0, 11'b00100000001, 10, -1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
